// File: rtl/dcache_arbiter.sv
// Two-requester arbiter in front of a single-port data cache (sync write, comb read).
// Optional build macro DCACHE_ARB_FIXED_PRIO_EN: requester 0 always wins conflicts.
module dcache_arbiter #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,

  input  logic              r0_req_i,
  input  logic              r0_we_i,
  input  logic [ADDR_W-1:0] r0_addr_i,
  input  logic [DATA_W-1:0] r0_wdata_i,
  output logic              r0_gnt_o,
  output logic              r0_rvalid_o,
  output logic [DATA_W-1:0] r0_rdata_o,

  input  logic              r1_req_i,
  input  logic              r1_we_i,
  input  logic [ADDR_W-1:0] r1_addr_i,
  input  logic [DATA_W-1:0] r1_wdata_i,
  output logic              r1_gnt_o,
  output logic              r1_rvalid_o,
  output logic [DATA_W-1:0] r1_rdata_o,

  output logic              mem_writeen_o,
  output logic              mem_readen_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_dato_o,
  input  logic [DATA_W-1:0] mem_dato_i,

  output logic [15:0]       conflict_cnt_o
);

  logic              gnt0, gnt1;
  logic              rvalid0_q, rvalid0_d;
  logic              rvalid1_q, rvalid1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic [15:0]       cnt_q, cnt_d;

`ifndef DCACHE_ARB_FIXED_PRIO_EN
  typedef enum logic {
    LAST_R0 = 1'b0,
    LAST_R1 = 1'b1
  } last_e;

  last_e last_q, last_d;
`endif

  // Grants are qualified by rst_ni so nothing reaches the cache during reset.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_ni) begin
`ifdef DCACHE_ARB_FIXED_PRIO_EN
      gnt0 = r0_req_i;
`else
      gnt0 = r0_req_i & (~r1_req_i | (last_q == LAST_R1));
`endif
      gnt1 = r1_req_i & ~gnt0;
    end
  end

  always_comb begin
    mem_writeen_o = 1'b0;
    mem_readen_o  = 1'b0;
    mem_addr_o    = '0;
    mem_dato_o    = '0;
    if (gnt0) begin
      mem_writeen_o = r0_we_i;
      mem_readen_o  = ~r0_we_i;
      mem_addr_o    = r0_addr_i;
      mem_dato_o    = r0_wdata_i;
    end else if (gnt1) begin
      mem_writeen_o = r1_we_i;
      mem_readen_o  = ~r1_we_i;
      mem_addr_o    = r1_addr_i;
      mem_dato_o    = r1_wdata_i;
    end
  end

`ifndef DCACHE_ARB_FIXED_PRIO_EN
  always_comb begin
    last_d = last_q;
    if (gnt0) begin
      last_d = LAST_R0;
    end else if (gnt1) begin
      last_d = LAST_R1;
    end
  end
`endif

  always_comb begin
    rvalid0_d = gnt0 & ~r0_we_i;
    rvalid1_d = gnt1 & ~r1_we_i;
    rdata0_d  = rvalid0_d ? mem_dato_i : rdata0_q;
    rdata1_d  = rvalid1_d ? mem_dato_i : rdata1_q;
    cnt_d     = cnt_q;
    if (r0_req_i && r1_req_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      cnt_q     <= '0;
`ifndef DCACHE_ARB_FIXED_PRIO_EN
      last_q    <= LAST_R1;
`endif
    end else begin
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      cnt_q     <= cnt_d;
`ifndef DCACHE_ARB_FIXED_PRIO_EN
      last_q    <= last_d;
`endif
    end
  end

  // A read in flight when reset asserts must never show up as rvalid.
  assign r0_rvalid_o    = rvalid0_q & rst_ni;
  assign r1_rvalid_o    = rvalid1_q & rst_ni;
  assign r0_rdata_o     = rdata0_q;
  assign r1_rdata_o     = rdata1_q;
  assign r0_gnt_o       = gnt0;
  assign r1_gnt_o       = gnt1;
  assign conflict_cnt_o = cnt_q;

endmodule
